// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   XLEN_DEF         : default datapath width (PC, branch target, instruction)
//   PC_STEP_DEF      : default byte distance between sequential fetches
//   RESET_VECTOR_DEF : default fetch PC after reset
//   fetch_entry_t    : one prefetch-buffer entry {pc, instr} at the default width
package fetch_pkg;

  localparam int              XLEN_DEF         = 32;
  localparam int              PC_STEP_DEF      = 4;
  localparam logic [XLEN_DEF-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// Single-clock FIFO with synchronous reset and synchronous clear.
//   clk, reset          : clock, synchronous active-high reset
//   clear               : empties the FIFO at the next edge (wins over push/pop)
//   push, push_data     : write one entry (caller guarantees not full)
//   pop, pop_data       : pop_data is the head entry; pop removes it (caller
//                         guarantees not empty)
//   count               : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule : sync_fifo

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: issues sequential, pipelined fetches to instruction
// memory and buffers returned words in a prefetch FIFO ahead of decode.
//   clk, reset                  : clock, synchronous active-high reset
//   branchSel, branchTarget     : redirect fetch; flushes buffered and in-flight work
//   stall                       : decode not accepting; head entry is held
//   imem_req_valid/addr/ready   : fetch request handshake (addr = fetch PC)
//   imem_rsp_valid/data         : in-order instruction responses
//   out_valid, PC, out_instr    : head of the prefetch FIFO towards decode
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int              FIFO_DEPTH   = 4,
  parameter int              PC_STEP      = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branchSel,
  input  logic [XLEN-1:0] branchTarget,
  input  logic            stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] out_instr
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]  fifo_count, tag_count, inflight;
  logic [XLEN-1:0]   tag_pc;
  logic [2*XLEN-1:0] head_entry;
  logic              accept, rsp_fire, rsp_keep, tag_pop, consume, credit_ok;

  // Outstanding requests are the live tags plus the stale ones still to be
  // dropped, so no separate in-flight counter is needed.
  assign inflight  = tag_count + drop_cnt_q;
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign out_valid = (fifo_count != '0);

  always_comb begin
    imem_req_valid = !reset && !branchSel && credit_ok;
    accept         = imem_req_valid && imem_req_ready;
    rsp_fire       = imem_rsp_valid && (inflight != '0);
    // Live responses pop their tag even during a redirect (the queue is
    // cleared anyway); stale ones only burn drop credit.
    tag_pop        = rsp_fire && (drop_cnt_q == '0);
    rsp_keep       = tag_pop && !branchSel;
    consume        = out_valid && !stall && !branchSel;

    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (branchSel) begin
      pc_d       = branchTarget;
      // Everything still outstanding is stale, minus a response landing now
      // (which is discarded in this same cycle).
      drop_cnt_d = inflight - {{(CNT_W-1){1'b0}}, rsp_fire};
    end else begin
      if (accept) pc_d = pc_q + XLEN'(PC_STEP);
      if (rsp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign imem_req_addr = pc_q;

  // Issue-PC tags travel alongside the requests and pair with responses in order.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (branchSel),
    .push      (accept),
    .push_data (pc_q),
    .pop       (tag_pop),
    .pop_data  (tag_pc),
    .count     (tag_count)
  );

  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_prefetch_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (branchSel),
    .push      (rsp_keep),
    .push_data ({tag_pc, imem_rsp_data}),
    .pop       (consume),
    .pop_data  (head_entry),
    .count     (fifo_count)
  );

  assign PC        = head_entry[2*XLEN-1:XLEN];
  assign out_instr = head_entry[XLEN-1:0];

endmodule : fetch_prefetch_unit

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit. The bench plays instruction
// memory (in-order queue of accepted requests, each answerable from a due
// cycle on) and predicts decode's view as a plain address stream: after reset
// or a redirect to T, decode must see T, T+4, T+8, ... with the word stored
// at each address, and never anything else.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, branchSel, stall;
  logic [31:0] branchTarget;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, out_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, PC, out_instr;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .XLEN(32), .RESET_VECTOR(RV), .FIFO_DEPTH(4), .PC_STEP(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .branchSel      (branchSel),
    .branchTarget   (branchTarget),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .PC             (PC),
    .out_instr      (out_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  req_t         pend_q[$];
  logic [31:0]  acc_log[$];
  fetch_entry_t cons_log[$];
  logic [31:0]  exp_pc, fetch_pc;
  logic         rand_ready, rand_lat, hold_rsp;
  int           extra_lat;

  logic         s_out_valid, s_req_valid;
  logic [31:0]  s_pc, s_req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // One clock cycle: drive inputs, sample at the falling edge, update the model.
  task automatic cycle(input logic rst, input logic br, input logic [31:0] tgt,
                       input logic stl);
    logic fire;
    int   last_due;
    reset          = rst;
    branchSel      = br;
    branchTarget   = tgt;
    stall          = stl;
    imem_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    fire = 1'b0;
    if (!rst && !hold_rsp && pend_q.size() > 0) begin
      if (pend_q[0].due <= cyc) fire = rand_lat ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    imem_rsp_valid = fire;
    imem_rsp_data  = fire ? mem_word(pend_q[0].addr) : $urandom;

    @(negedge clk);
    s_out_valid = out_valid;
    s_req_valid = imem_req_valid;
    s_pc        = PC;
    s_req_addr  = imem_req_addr;

    if (rst) begin
      pend_q.delete();
      exp_pc   = RV;
      fetch_pc = RV;
    end else begin
      if (out_valid) begin
        checks++;
        if (PC !== exp_pc || out_instr !== mem_word(exp_pc)) begin
          failures++;
          $display("FAIL head_entry cyc=%0d got pc=%h instr=%h expected pc=%h instr=%h",
                   cyc, PC, out_instr, exp_pc, mem_word(exp_pc));
        end
      end
      if (br) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          failures++;
          $display("FAIL req_in_branch_cycle cyc=%0d got valid=%b expected 0", cyc, imem_req_valid);
        end
      end
      if (out_valid && !stl && !br) begin
        cons_log.push_back('{pc: PC, instr: out_instr});
        exp_pc += 32'(PC_STEP_DEF);
      end
      if (fire) void'(pend_q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (imem_req_addr !== fetch_pc) begin
          failures++;
          $display("FAIL fetch_addr cyc=%0d got %h expected %h", cyc, imem_req_addr, fetch_pc);
        end
        acc_log.push_back(imem_req_addr);
        last_due = (pend_q.size() > 0) ? pend_q[$].due : 0;
        begin
          int due;
          due = cyc + 1 + (rand_lat ? int'($urandom_range(0, 2)) : extra_lat);
          if (due < last_due) due = last_due;
          pend_q.push_back('{addr: imem_req_addr, due: due});
        end
        fetch_pc += 32'(PC_STEP_DEF);
      end
      if (br) begin
        exp_pc   = tgt;
        fetch_pc = tgt;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rand_ready = 1'b0;
    rand_lat   = 1'b0;
    hold_rsp   = 1'b0;
    extra_lat  = 0;
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (s_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got %b expected 0", s_out_valid);
    end
    checks++;
    if (s_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_req_valid got %b expected 0", s_req_valid);
    end
    checks++;
    if (s_req_addr !== RV) begin
      failures++;
      $display("FAIL reset_req_addr got %h expected %h", s_req_addr, RV);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (s_out_valid !== (k >= 2)) begin
        failures++;
        $display("FAIL seq_out_valid k=%0d got %b expected %b", k, s_out_valid, (k >= 2));
      end
      if (k >= 2) begin
        checks++;
        if (s_pc !== 32'(4 * (k - 2))) begin
          failures++;
          $display("FAIL seq_pc k=%0d got %h expected %h", k, s_pc, 32'(4 * (k - 2)));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (k >= 2) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_pc !== 32'h0) begin
          failures++;
          $display("FAIL stall_hold k=%0d got valid=%b pc=%h expected valid=1 pc=0", k, s_out_valid, s_pc);
        end
      end
    end
    checks++;
    if (s_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_full_no_req got %b expected 0", s_req_valid);
    end
    for (int j = 0; j < 4; j++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (s_out_valid !== 1'b1 || s_pc !== 32'(4 * j)) begin
        failures++;
        $display("FAIL stall_drain j=%0d got valid=%b pc=%h expected valid=1 pc=%h", j, s_out_valid, s_pc, 32'(4 * j));
      end
    end
    for (int j = 0; j < 4; j++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Hold responses until two requests are outstanding, then redirect with no
  // response in the redirect cycle so both become stale.
  task automatic build_two_inflight(input string name);
    int guard;
    guard = 0;
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    hold_rsp = 1'b1;
    while (pend_q.size() < 2 && guard < 20) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      guard++;
    end
    checks++;
    if (pend_q.size() < 2) begin
      failures++;
      $display("FAIL %s_setup got inflight=%0d expected 2", name, pend_q.size());
    end
  endtask

  task automatic test_branch_drain();
    int n;
    do_reset();
    build_two_inflight("branch_drain");
    n = cons_log.size();
    cycle(1'b0, 1'b1, 32'h8000_0000, 1'b0);
    hold_rsp = 1'b0;
    for (int k = 0; k < 15; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (cons_log.size() < n + 2) begin
      failures++;
      $display("FAIL branch_drain_count got %0d expected >=2", cons_log.size() - n);
    end else if (cons_log[n].pc !== 32'h8000_0000 || cons_log[n+1].pc !== 32'h8000_0004) begin
      failures++;
      $display("FAIL branch_drain_pcs got %h,%h expected 80000000,80000004", cons_log[n].pc, cons_log[n+1].pc);
    end
  endtask

  task automatic test_branch_rsp();
    int n;
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (pend_q.size() == 0) begin
      failures++;
      $display("FAIL branch_rsp_setup got inflight=0 expected >=1");
    end
    n = cons_log.size();
    cycle(1'b0, 1'b1, 32'h0000_1000, 1'b0);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (cons_log.size() <= n) begin
      failures++;
      $display("FAIL branch_rsp_count got 0 expected >=1");
    end else if (cons_log[n].pc !== 32'h0000_1000) begin
      failures++;
      $display("FAIL branch_rsp_first_pc got %h expected 00001000", cons_log[n].pc);
    end
  endtask

  task automatic test_reset_drain();
    int n;
    do_reset();
    build_two_inflight("reset_drain");
    cycle(1'b0, 1'b1, 32'h4000_0000, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    hold_rsp = 1'b0;
    n = cons_log.size();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (s_out_valid !== 1'b0 || s_req_addr !== RV) begin
      failures++;
      $display("FAIL reset_drain_after got valid=%b addr=%h expected valid=0 addr=%h", s_out_valid, s_req_addr, RV);
    end
    for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (cons_log.size() <= n) begin
      failures++;
      $display("FAIL reset_drain_count got 0 expected >=1");
    end else if (cons_log[n].pc !== RV) begin
      failures++;
      $display("FAIL reset_drain_first_pc got %h expected %h", cons_log[n].pc, RV);
    end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    n = acc_log.size();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (acc_log.size() < n + 2) begin
      failures++;
      $display("FAIL wrap_count got %0d expected >=2", acc_log.size() - n);
    end else if (acc_log[n] !== 32'hFFFF_FFFC || acc_log[n+1] !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap_addr got %h,%h expected fffffffc,00000000", acc_log[n], acc_log[n+1]);
    end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    rand_ready = 1'b1;
    rand_lat   = 1'b1;
    n = cons_log.size();
    for (int k = 0; k < 3000; k++) begin
      logic rst, br, stl;
      rst = ($urandom_range(0, 499) == 0);
      br  = ($urandom_range(0, 29) == 0);
      stl = ($urandom_range(0, 3) == 0);
      cycle(rst, br, $urandom & 32'hFFFF_FFFC, stl);
    end
    checks++;
    if (cons_log.size() - n < 100) begin
      failures++;
      $display("FAIL random_progress got %0d consumed expected >=100", cons_log.size() - n);
    end
  endtask

  initial begin
    reset          = 1'b1;
    branchSel      = 1'b0;
    branchTarget   = '0;
    stall          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    rand_ready     = 1'b0;
    rand_lat       = 1'b0;
    hold_rsp       = 1'b0;
    extra_lat      = 0;
    exp_pc         = RV;
    fetch_pc       = RV;

    test_reset();
    test_sequential();
    test_stall();
    test_branch_drain();
    test_branch_rsp();
    test_reset_drain();
    test_wrap();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_prefetch_unit
